// File: rtl/mult_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes have priority, multiplier results
// that lose arbitration are queued in order, cancelled on WAW, and drained on idle cycles.
module mult_wb_arbiter #(
   parameter int DEPTH   = 8,
   parameter int RESERVE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mult_rd_addr,
   input  logic [31:0] mult_rd_data,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_rd_addr,
   input  logic [31:0] pipe_rd_data,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pend_flags,
   output logic        stall_o,
   output logic        ovf_err
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C  = (PW+1)'(DEPTH);
   localparam logic [PW:0] STALL_TH = (PW+1)'(DEPTH - RESERVE);

   logic [PW:0]      wptr_r, rptr_r;
   logic [DEPTH-1:0] valid_r;
   logic [4:0]       addr_r [DEPTH];
   logic [31:0]      data_r [DEPTH];
   logic             rf_we_r, from_mult_r, ovf_r;
   logic [4:0]       rf_waddr_r;
   logic [31:0]      rf_wdata_r;

   logic [PW:0]      count_s;
   logic [PW-1:0]    widx_s, ridx_s;
   logic             pipe_act_s, mult_act_s, empty_s, full_s;
   logic             pop_s, bypass_s, push_s, drop_s, push_valid_s;
   logic [DEPTH-1:0] valid_s;
   logic             rf_we_s, from_mult_s;
   logic [4:0]       rf_waddr_s;
   logic [31:0]      rf_wdata_s;
   logic [31:0]      pend_s;

   assign count_s      = wptr_r - rptr_r;
   assign widx_s       = wptr_r[PW-1:0];
   assign ridx_s       = rptr_r[PW-1:0];
   assign pipe_act_s   = pipe_we && (pipe_rd_addr != 5'd0);
   assign mult_act_s   = (mult_rd_addr != 5'd0);
   assign empty_s      = (count_s == {(PW+1){1'b0}});
   assign full_s       = (count_s == DEPTH_C);
   assign pop_s        = !pipe_act_s && !empty_s;
   assign bypass_s     = !pipe_act_s && empty_s && mult_act_s;
   // A full FIFO accepts a push only when the same cycle pops a slot free.
   assign push_s       = mult_act_s && !bypass_s && (!full_s || pop_s);
   assign drop_s       = mult_act_s && !bypass_s && full_s && !pop_s;
   assign push_valid_s = !(pipe_act_s && (mult_rd_addr == pipe_rd_addr));

   // Next entry-valid vector: WAW kill, then pop clear, then push (push may reuse the popped slot).
   always_comb begin
      valid_s = valid_r;
      for (int i = 0; i < DEPTH; i++) begin
         if (pipe_act_s && (addr_r[i] == pipe_rd_addr)) begin
            valid_s[i] = 1'b0;
         end else begin
            valid_s[i] = valid_r[i];
         end
      end
      if (pop_s) begin
         valid_s[ridx_s] = 1'b0;
      end else begin
         valid_s = valid_s;
      end
      if (push_s) begin
         valid_s[widx_s] = push_valid_s;
      end else begin
         valid_s = valid_s;
      end
   end

   // Write-port source selection with pipeline priority.
   always_comb begin
      rf_we_s     = 1'b0;
      rf_waddr_s  = rf_waddr_r;
      rf_wdata_s  = rf_wdata_r;
      from_mult_s = 1'b0;
      if (pipe_act_s) begin
         rf_we_s    = 1'b1;
         rf_waddr_s = pipe_rd_addr;
         rf_wdata_s = pipe_rd_data;
      end else if (pop_s) begin
         rf_we_s     = valid_r[ridx_s];
         rf_waddr_s  = addr_r[ridx_s];
         rf_wdata_s  = data_r[ridx_s];
         from_mult_s = 1'b1;
      end else if (bypass_s) begin
         rf_we_s     = 1'b1;
         rf_waddr_s  = mult_rd_addr;
         rf_wdata_s  = mult_rd_data;
         from_mult_s = 1'b1;
      end else begin
         rf_we_s = 1'b0;
      end
   end

   // Control state: pointers, entry valids, sticky overflow and the registered write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r      <= {(PW+1){1'b0}};
         rptr_r      <= {(PW+1){1'b0}};
         valid_r     <= {DEPTH{1'b0}};
         ovf_r       <= 1'b0;
         rf_we_r     <= 1'b0;
         rf_waddr_r  <= 5'd0;
         rf_wdata_r  <= 32'd0;
         from_mult_r <= 1'b0;
      end else begin
         valid_r     <= valid_s;
         wptr_r      <= push_s ? wptr_r + (PW+1)'(1) : wptr_r;
         rptr_r      <= pop_s  ? rptr_r + (PW+1)'(1) : rptr_r;
         ovf_r       <= ovf_r | drop_s;
         rf_we_r     <= rf_we_s;
         rf_waddr_r  <= rf_waddr_s;
         rf_wdata_r  <= rf_wdata_s;
         from_mult_r <= from_mult_s;
      end
   end

   // Entry payload storage; only meaningful while the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (push_s) begin
         addr_r[widx_s] <= mult_rd_addr;
         data_r[widx_s] <= mult_rd_data;
      end
   end

   // Pending destinations: live queued results plus a multiplier write now on the port.
   always_comb begin
      pend_s = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_r[i]) begin
            pend_s = pend_s | (32'd1 << addr_r[i]);
         end else begin
            pend_s = pend_s;
         end
      end
      if (rf_we_r && from_mult_r) begin
         pend_s = pend_s | (32'd1 << rf_waddr_r);
      end else begin
         pend_s = pend_s;
      end
      pend_s[0] = 1'b0;
   end

   assign rf_we      = rf_we_r;
   assign rf_waddr   = rf_waddr_r;
   assign rf_wdata   = rf_wdata_r;
   assign ovf_err    = ovf_r;
   assign pend_flags = pend_s;
   assign stall_o    = (count_s >= STALL_TH);

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Scoreboard bench for mult_wb_arbiter: a queue-based reference model predicts each
// cycle's write port and status; a monitor pops and compares after every clock edge.
module tb_mult_wb_arbiter;

   localparam int DEPTH   = 8;
   localparam int RESERVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  mult_rd_addr = 5'd0;
   logic [31:0] mult_rd_data = 32'd0;
   logic        pipe_we = 1'b0;
   logic [4:0]  pipe_rd_addr = 5'd0;
   logic [31:0] pipe_rd_data = 32'd0;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pend_flags;
   logic        stall_o;
   logic        ovf_err;

   mult_wb_arbiter #(.DEPTH(DEPTH), .RESERVE(RESERVE)) dut (
      .clk(clk), .rst(rst),
      .mult_rd_addr(mult_rd_addr), .mult_rd_data(mult_rd_data),
      .pipe_we(pipe_we), .pipe_rd_addr(pipe_rd_addr), .pipe_rd_data(pipe_rd_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_flags(pend_flags), .stall_o(stall_o), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   typedef struct {
      bit          we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] pend;
      bit          stall;
      bit          ovf;
   } exp_t;

   ent_t mq[$];
   exp_t eq[$];
   bit   m_ovf = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference: in-order list of queued results; pipeline wins, older results drain first.
   task automatic model_step(input bit pwe, input logic [4:0] pa_addr, input logic [31:0] pd,
                             input logic [4:0] ma_addr, input logic [31:0] md);
      exp_t e;
      ent_t n;
      ent_t h;
      bit   pa, ma, fm;
      pa = pwe && (pa_addr != 5'd0);
      ma = (ma_addr != 5'd0);
      fm = 1'b0;
      e.we = 1'b0; e.a = 5'd0; e.d = 32'd0;
      n.a = ma_addr; n.d = md; n.v = 1'b1;
      if (pa) begin
         e.we = 1'b1; e.a = pa_addr; e.d = pd;
         foreach (mq[i]) if (mq[i].a == pa_addr) mq[i].v = 1'b0;
         if (ma) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else begin
               n.v = (ma_addr != pa_addr);
               mq.push_back(n);
            end
         end
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         e.we = h.v; e.a = h.a; e.d = h.d; fm = h.v;
         if (ma) mq.push_back(n);
      end else if (ma) begin
         e.we = 1'b1; e.a = ma_addr; e.d = md; fm = 1'b1;
      end
      e.pend = 32'd0;
      foreach (mq[i]) if (mq[i].v) e.pend[mq[i].a] = 1'b1;
      if (fm) e.pend[e.a] = 1'b1;
      e.pend[0] = 1'b0;
      e.stall = (mq.size() >= DEPTH - RESERVE);
      e.ovf = m_ovf;
      eq.push_back(e);
   endtask

   task automatic step(input bit pwe, input logic [4:0] pa_addr, input logic [31:0] pd,
                       input logic [4:0] ma_addr, input logic [31:0] md);
      @(negedge clk);
      pipe_we = pwe; pipe_rd_addr = pa_addr; pipe_rd_data = pd;
      mult_rd_addr = ma_addr; mult_rd_data = md;
      model_step(pwe, pa_addr, pd, ma_addr, md);
   endtask

   task automatic rand_step(input int pipe_pct, input int mult_pct);
      logic [4:0] pa, ma;
      pa = ($urandom_range(0, 99) < pipe_pct) ? 5'($urandom_range(1, 12)) : 5'($urandom_range(0, 1) * 3);
      ma = ($urandom_range(0, 99) < mult_pct) ? 5'($urandom_range(1, 12)) : 5'd0;
      step(($urandom_range(0, 99) < pipe_pct), pa, $urandom, ma, $urandom);
   endtask

   // Monitor: one expectation per clock edge after reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
            if (e.we) begin
               chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.a});
               chk("rf_wdata", rf_wdata, e.d);
            end
            chk("pend_flags", pend_flags, e.pend);
            chk("stall_o", {31'd0, stall_o}, {31'd0, e.stall});
            chk("ovf_err", {31'd0, ovf_err}, {31'd0, e.ovf});
         end
      end
   end

   initial begin
      #1;
      chk("reset rf_we", {31'd0, rf_we}, 32'd0);
      chk("reset rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("reset rf_wdata", rf_wdata, 32'd0);
      chk("reset pend_flags", pend_flags, 32'd0);
      chk("reset stall_o", {31'd0, stall_o}, 32'd0);
      chk("reset ovf_err", {31'd0, ovf_err}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // bypass
      step(1'b0, 5'd0, 32'd0, 5'd5, 32'h1234_5678);
      step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      // conflict then drain
      step(1'b1, 5'd3, 32'hA, 5'd7, 32'hB);
      step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      // WAW kill of a buffered x9
      step(1'b1, 5'd2, 32'h1, 5'd9, 32'h99);
      step(1'b1, 5'd2, 32'h2, 5'd0, 32'd0);
      step(1'b1, 5'd2, 32'h3, 5'd0, 32'd0);
      step(1'b1, 5'd9, 32'h55, 5'd0, 32'd0);
      repeat (3) step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);
      // fill to overflow while the pipeline holds the port
      for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 5'd1, 32'(i), 5'(i + 2), 32'hC0 + 32'(i));
      step(1'b0, 5'd0, 32'd0, 5'd20, 32'hF00D);
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);

      // async reset with five entries buffered
      for (int i = 0; i < 5; i++) step(1'b1, 5'd1, 32'd7, 5'(i + 3), 32'hD0 + 32'(i));
      @(negedge clk);
      pipe_we = 1'b0; pipe_rd_addr = 5'd0; mult_rd_addr = 5'd0;
      #2 rst = 1'b1;
      #1;
      chk("midreset rf_we", {31'd0, rf_we}, 32'd0);
      chk("midreset rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("midreset rf_wdata", rf_wdata, 32'd0);
      chk("midreset pend_flags", pend_flags, 32'd0);
      chk("midreset stall_o", {31'd0, stall_o}, 32'd0);
      chk("midreset ovf_err", {31'd0, ovf_err}, 32'd0);
      eq.delete(); mq.delete(); m_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);

      // bursts crossing pointer wrap
      for (int b = 0; b < 20; b++) begin
         int np, nd;
         np = $urandom_range(1, 6);
         nd = $urandom_range(1, 6);
         for (int i = 0; i < np; i++) rand_step(100, 90);
         for (int i = 0; i < nd; i++) rand_step(10, 40);
      end
      // free-running random traffic
      for (int i = 0; i < 500; i++) rand_step(50, 60);
      for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 5'd0, 32'd0, 5'd0, 32'd0);

      for (int i = 0; i < 5 && eq.size() > 0; i++) @(posedge clk);
      #2;
      if (eq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked", eq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_wb_arbiter.md
# mult_wb_arbiter

Write-back arbiter between the pipelined multiplier manager and the register file's single write port. It accepts fixed-latency multiplier results (`rd_addr`/`rd_data`) alongside the main pipeline's MEM/WB write, and always gives the pipeline priority. Multiplier results that lose arbitration are buffered in an in-order FIFO and drained on idle write-port cycles. It also cancels stale buffered results on write-after-write, and exports pending-destination flags and a stall request to the hazard/stall controller.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 4.
- `RESERVE`, default 4: free slots kept for results already in flight in the multiplier; must be ≥ `MULT_PPL_STAGE`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mult_rd_addr` in 5: multiplier result destination; 0 means no result this cycle.
- `mult_rd_data` in 32: multiplier result.
- `pipe_we` in 1: main-pipeline write enable.
- `pipe_rd_addr` in 5: main-pipeline destination.
- `pipe_rd_data` in 32: main-pipeline write data.
- `rf_we` out 1: register-file write enable (registered).
- `rf_waddr` out 5: register-file write address (registered).
- `rf_wdata` out 32: register-file write data (registered).
- `pend_flags` out 32: bit r = 1 while a multiplier result for x_r is buffered or being written.
- `stall_o` out 1: request to stop issuing multiply instructions.
- `ovf_err` out 1: sticky error flag; set when a push is dropped.

## Operation
- Definitions:
  - pipe_act = `pipe_we` & (`pipe_rd_addr` != 0).
  - mult_act = `mult_rd_addr` != 0.
- FIFO entry format: {valid, addr[4:0], data[31:0]}. Read/write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. count = wptr − rptr.
- Kill rule, applied every cycle with pipe_act: every FIFO entry with addr == `pipe_rd_addr` gets valid cleared. An entry pushed in the same cycle is also killed if its addr matches (the pipeline write is younger).
- Port selection, in priority order:
  1. pipe_act: write the pipeline data. If mult_act, push the multiplier result (killed if its addr matches). No pop.
  2. FIFO non-empty: pop the head. Drive rf_we = head.valid. If mult_act, push in the same cycle.
  3. FIFO empty and mult_act: bypass the result straight to the rf_* registers, no push.
  4. Otherwise rf_we = 0.
- An invalid head still costs one pop cycle, with rf_we = 0.
- Push when count == DEPTH: the result is dropped and `ovf_err` is set. `ovf_err` is cleared only by `rst`.
- `stall_o` = (count ≥ DEPTH − RESERVE). This is combinational from registered pointers.
- `pend_flags`:
  - OR over valid FIFO entries of (1 << addr).
  - Also sets bit `rf_waddr` when `rf_we` is set and the current write came from the multiplier path.
  - Bit 0 is forced to 0.
- Write order to any given register equals arrival order. Killed entries never write.

## Timing
- Reset values, asynchronous: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, pointers=0, all entry valid bits=0, `ovf_err`=0. Consequently `pend_flags`=0 and `stall_o`=0.
- Latencies:
  - Pipeline write: input in cycle t reaches `rf_*` at t+1.
  - Bypassed multiplier result: also t+1.
  - Buffered result: t+1+k, where k is the number of cycles it waits for older entries and for the pipeline to release the port.
- `pend_flags` and `stall_o` reflect post-edge state; there is no same-cycle input path into them.
- Simultaneous push and pop at count == DEPTH is legal: the pop frees a slot first, so no overflow.
- Simultaneous push and pop at count == 0 cannot occur, because the bypass path handles that case.
- Reset asserted mid-operation discards all buffered results without writing them. Outputs go to reset values asynchronously.

## Test plan
- Bypass: FIFO empty, `mult_rd_addr`=5, `mult_rd_data`=0x12345678, `pipe_we`=0 -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x12345678; `pend_flags`=0x20 during that cycle only.
- Conflict and drain:
  - Cycle 0: pipe writes x3=0xA, mult delivers x7=0xB.
  - Cycle 1: `rf_*` = x3/0xA, count=1, `pend_flags`=0x80.
  - Cycle 2: with `pipe_we`=0, `rf_*` = x7/0xB, count=0.
- WAW kill:
  - Buffered x9 (pipe busy for 3 cycles, then a pipe write to x9=0x55).
  - The buffered x9 entry pops with `rf_we`=0, so x9 receives only 0x55.
  - `pend_flags` bit 9 clears the cycle after the kill.
- Full/stall/overflow (DEPTH=8, RESERVE=4):
  - Hold pipe_act while pushing every cycle.
  - `stall_o` rises when count reaches 4.
  - On the 9th push `ovf_err`=1 and count stays 8.
- Wrap-around: 20 alternating push/pop bursts crossing pointer wrap -> `rf_waddr`/`rf_wdata` sequence matches a reference queue exactly.
- Async reset with count=5 mid-stream -> all outputs 0 immediately, no subsequent write of the old entries.
